// File: rtl/reg_serial_reader_if.sv
// ---------------------------------------------------------------------------
// reg_serial_reader_if
//   Bundles the capture request, the captured register value and the serial
//   valid/ready link of reg_serial_reader into one port.
//
//   Signals
//     start      capture request (honoured only while the reader is idle)
//     data_in    register value captured on an accepted start
//     ser_ready  sink accepts the current bit this cycle
//     ser_valid  current bit on ser_out is valid
//     ser_out    current serial bit (0 whenever ser_valid is 0)
//     busy       reader is shifting or finishing a frame
//     done       one-cycle pulse after the last bit is accepted
//
//   Modports
//     master  the side that requests frames and sinks the serial stream
//     slave   the reader itself
// ---------------------------------------------------------------------------
interface reg_serial_reader_if #(
  parameter int SIZE = 32
);
  logic            start;
  logic [SIZE-1:0] data_in;
  logic            ser_ready;
  logic            ser_valid;
  logic            ser_out;
  logic            busy;
  logic            done;

  modport master (
    output start,
    output data_in,
    output ser_ready,
    input  ser_valid,
    input  ser_out,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    input  ser_ready,
    output ser_valid,
    output ser_out,
    output busy,
    output done
  );
endinterface

// File: rtl/reg_serial_reader.sv
// ---------------------------------------------------------------------------
// reg_serial_reader
//   Parallel-in, serial-out unloader. Captures a SIZE-bit register snapshot
//   in one cycle, then shifts it out LSB-first, one bit per accepted
//   valid/ready transfer, optionally followed by one even-parity bit.
//
//   Parameters
//     SIZE    number of data bits per frame (>= 2)
//     PARITY  1 = append even parity of the captured value after the MSB
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   reg_serial_reader_if.slave : start, data_in, ser_ready in;
//           ser_valid, ser_out, busy, done out
//
//   Timing: start sampled at edge t -> bit i presented in cycle t+1+i with
//   the sink always ready, done in cycle t+N+1, idle again in cycle t+N+2,
//   where N = SIZE + PARITY.
// ---------------------------------------------------------------------------
module reg_serial_reader #(
  parameter int SIZE   = 32,
  parameter int PARITY = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_serial_reader_if.slave   bus
);

  localparam int N  = SIZE + PARITY;
  localparam int CW = $clog2(SIZE + 2);

  localparam logic [CW-1:0] CNT_SIZE = CW'(SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [SIZE-1:0] sr_q, sr_d;
  logic            par_q, par_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            shifting;
  logic            bit_sel;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sr_d    = bus.data_in;
          // Parity comes from the captured value, not from the shifted bits.
          par_d   = ^bus.data_in;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // ser_valid is always high in SHIFT, so ser_ready alone marks a
        // transfer. Without it everything holds.
        if (bus.ser_ready) begin
          sr_d  = sr_q >> 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so nothing on the input
  // side (start, data_in, ser_ready) reaches an output within a cycle.
  // -------------------------------------------------------------------------
  assign shifting = (state_q == ST_SHIFT);

  // The count only reaches SIZE inside SHIFT when a parity bit is appended.
  assign bit_sel = ((PARITY != 0) && (cnt_q == CNT_SIZE)) ? par_q : sr_q[0];

  assign bus.ser_valid = shifting;
  assign bus.ser_out   = shifting & bit_sel;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_reg_serial_reader.sv
module tb_reg_serial_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s = 1'b1;
  logic        ready_s = 1'b1;
  logic [31:0] data_s  = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  reg_serial_reader_if #(.SIZE(32)) if0 ();
  reg_serial_reader_if #(.SIZE(32)) if1 ();

  assign if0.start     = start_s;
  assign if0.data_in   = data_s;
  assign if0.ser_ready = ready_s;
  assign if1.start     = start_s;
  assign if1.data_in   = data_s;
  assign if1.ser_ready = ready_s;

  reg_serial_reader #(.SIZE(32), .PARITY(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  reg_serial_reader #(.SIZE(32), .PARITY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Model: a frame is a queue of bits still to be sent. The head is on the
  // wire while the queue is non-empty; an accepted bit is popped; emptying
  // the queue yields one done cycle before the next start can be taken.
  bit q0[$];
  bit q1[$];
  bit dn0 = 1'b0;
  bit dn1 = 1'b0;
  bit armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      dn0   = 1'b0;
      dn1   = 1'b0;
      armed = 1'b1;
    end else begin
      if (dn0) dn0 = 1'b0;
      else if (q0.size() != 0) begin
        if (ready_s) begin
          void'(q0.pop_front());
          dn0 = (q0.size() == 0);
        end
      end else if (start_s) begin
        for (int i = 0; i < 32; i++) q0.push_back(data_s[i]);
      end

      if (dn1) dn1 = 1'b0;
      else if (q1.size() != 0) begin
        if (ready_s) begin
          void'(q1.pop_front());
          dn1 = (q1.size() == 0);
        end
      end else if (start_s) begin
        for (int i = 0; i < 32; i++) q1.push_back(data_s[i]);
        q1.push_back(^data_s);
      end
    end
  end

  logic [3:0] e0, e1;

  // Cycle compare of {ser_valid, ser_out, busy, done} for both instances.
  always @(negedge clk) begin
    if (armed) begin
      e0 = {q0.size() != 0, (q0.size() != 0) ? q0[0] : 1'b0, (q0.size() != 0) || dn0, dn0};
      e1 = {q1.size() != 0, (q1.size() != 0) ? q1[0] : 1'b0, (q1.size() != 0) || dn1, dn1};
      check("dut0_valid_out_busy_done",
            {28'd0, if0.ser_valid, if0.ser_out, if0.busy, if0.done}, {28'd0, e0});
      check("dut1_valid_out_busy_done",
            {28'd0, if1.ser_valid, if1.ser_out, if1.busy, if1.done}, {28'd0, e1});
    end
  end

  // Runs one frame. k counts cycles after the start edge (cycle t+k).
  task automatic run_frame(input logic [31:0] d, input int stall_len, input int ign_k,
                           input int abort_k, output int done0, output int done1,
                           output logic [31:0] bits0, output int nb0, output logic pbit1);
    int nb1;
    done0 = 0; done1 = 0; bits0 = '0; nb0 = 0; nb1 = 0; pbit1 = 1'b0;
    @(posedge clk); #1;
    start_s = 1'b1;
    data_s  = d;
    @(posedge clk); #1;
    start_s = 1'b0;
    data_s  = ~d;
    for (int k = 1; k < 80; k++) begin
      ready_s = !(stall_len > 0 && k >= 6 && k < 6 + stall_len);
      if (ign_k > 0 && (k == ign_k || k == ign_k + 1)) begin
        start_s = 1'b1;
        data_s  = 32'hFFFF_FFFF;
      end else begin
        start_s = 1'b0;
      end
      rst = (abort_k > 0 && k == abort_k);
      @(negedge clk);
      if (if0.ser_valid && ready_s && !rst) begin
        if (nb0 < 32) bits0[nb0] = if0.ser_out;
        nb0++;
      end
      if (if1.ser_valid && ready_s && !rst) begin
        if (nb1 == 32) pbit1 = if1.ser_out;
        nb1++;
      end
      if (if0.done && done0 == 0) done0 = k;
      if (if1.done && done1 == 0) done1 = k;
      if (abort_k > 0 && k == abort_k + 4) break;
      if (done1 > 0 && k == done1 + 1) break;
      @(posedge clk); #1;
    end
    rst     = 1'b0;
    start_s = 1'b0;
    ready_s = 1'b1;
  endtask

  int          d0, d1, nb;
  logic [31:0] b0;
  logic        pb;

  initial begin
    // Reset held two cycles with start high: nothing may be captured.
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    start_s = 1'b0;
    @(negedge clk);
    check("reset_busy0", {31'd0, if0.busy}, 32'd0);
    check("reset_valid1", {31'd0, if1.ser_valid}, 32'd0);

    // Basic frame
    run_frame(32'hA5A5_0F0F, 0, 0, 0, d0, d1, b0, nb, pb);
    $display("frame A5A50F0F: bits0=%08h done0=+%0d done1=+%0d parity=%0d", b0, d0, d1, pb);
    check("basic_bits", b0, 32'hA5A5_0F0F);
    check("basic_done0_cycle", d0, 33);
    check("basic_done1_cycle", d1, 34);
    check("basic_parity", {31'd0, pb}, 32'd0);

    // Parity
    run_frame(32'h0000_0007, 0, 0, 0, d0, d1, b0, nb, pb);
    $display("frame 00000007: bits0=%08h parity=%0d", b0, pb);
    check("parity7_bit", {31'd0, pb}, 32'd1);
    check("parity7_bits", b0, 32'h0000_0007);
    run_frame(32'h0000_0003, 0, 0, 0, d0, d1, b0, nb, pb);
    $display("frame 00000003: bits0=%08h parity=%0d", b0, pb);
    check("parity3_bit", {31'd0, pb}, 32'd0);

    // Backpressure: ready low for 3 cycles while bit 5 is presented
    run_frame(32'h1234_5678, 3, 0, 0, d0, d1, b0, nb, pb);
    $display("frame 12345678 stall3: bits0=%08h done0=+%0d done1=+%0d parity=%0d", b0, d0, d1, pb);
    check("stall_bits", b0, 32'h1234_5678);
    check("stall_done0_cycle", d0, 36);
    check("stall_done1_cycle", d1, 37);
    check("stall_parity", {31'd0, pb}, 32'd1);

    // Start toggled mid-frame with all-ones data must be ignored
    run_frame(32'h0F0F_00F0, 0, 10, 0, d0, d1, b0, nb, pb);
    $display("frame 0F0F00F0 ignored-start: bits0=%08h done0=+%0d", b0, d0);
    check("ignstart_bits", b0, 32'h0F0F_00F0);
    check("ignstart_done0_cycle", d0, 33);
    repeat (5) @(negedge clk);
    check("ignstart_no_second_frame", {31'd0, if0.busy | if1.busy}, 32'd0);

    // Reset while bit 10 is presented
    run_frame(32'hDEAD_BEEF, 0, 0, 11, d0, d1, b0, nb, pb);
    $display("frame DEADBEEF abort@bit10: bits_sent=%0d done0=%0d done1=%0d", nb, d0, d1);
    check("abort_bits_sent", nb, 10);
    check("abort_no_done0", d0, 0);
    check("abort_no_done1", d1, 0);
    check("abort_partial_bits", b0 & 32'h0000_03FF, 32'h0000_02EF);

    // Fresh frame after the abort restarts from bit 0
    run_frame(32'hCAFE_F00D, 0, 0, 0, d0, d1, b0, nb, pb);
    $display("frame CAFEF00D after abort: bits0=%08h done0=+%0d parity=%0d", b0, d0, pb);
    check("restart_bits", b0, 32'hCAFE_F00D);
    check("restart_done0_cycle", d0, 33);
    check("restart_parity", {31'd0, pb}, 32'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
